// File: rtl/alu_pkg.sv
// ALU operation codes, MIPS opcode/funct constants and decode helpers
// shared by the issue stage and the ALU.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b1110;
  localparam logic [3:0] ALU_SUB  = 4'b0100;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0111;
  localparam logic [3:0] ALU_SLL  = 4'b1010;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;
  localparam logic [3:0] ALU_JR   = 4'b1100;
  localparam logic [3:0] ALU_ADDU = 4'b0001;
  localparam logic [3:0] ALU_SUBU = 4'b0101;
  localparam logic [3:0] ALU_LUI  = 4'b0110;
  localparam logic [3:0] ALU_NOP  = 4'b0000;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_XOR = 6'b100110;
  localparam logic [5:0] F_SLL = 6'b000000;
  localparam logic [5:0] F_SRL = 6'b000010;
  localparam logic [5:0] F_SRA = 6'b000011;
  localparam logic [5:0] F_JR  = 6'b001000;

  // control bits carried alongside the operands
  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic branch;
    logic jump_reg;
    logic illegal;
  } alu_ctl_t;

endpackage

// File: rtl/alu_decode_comb.sv
// Combinational MIPS decode: instruction fields plus register
// operands to ALUctr, A/B operands, destination and controls.
module alu_decode_comb
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTR_W  = 4
) (
  input  logic [5:0]        op,
  input  logic [4:0]        rt,
  input  logic [15:0]       imm,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  output logic [CTR_W-1:0]  aluctr,
  output logic [DATA_W-1:0] a,
  output logic [DATA_W-1:0] b,
  output logic [4:0]        wr_reg,
  output alu_ctl_t          ctl
);

  logic [5:0]        funct;
  logic [4:0]        rd;
  logic [4:0]        shamt;
  logic              is_r;
  logic [DATA_W-1:0] simm;
  logic [DATA_W-1:0] zimm;
  logic [DATA_W-1:0] zsh;

  assign funct = imm[5:0];
  assign rd    = imm[15:11];
  assign shamt = imm[10:6];
  assign is_r  = (op == OP_RTYPE);
  assign simm  = {{(DATA_W-16){imm[15]}}, imm};
  assign zimm  = {{(DATA_W-16){1'b0}}, imm};
  assign zsh   = {{(DATA_W-5){1'b0}}, shamt};

  always_comb begin
    aluctr = CTR_W'(ALU_NOP);
    a      = '0;
    b      = '0;
    wr_reg = '0;
    ctl    = '0;
    unique case (1'b1)
      is_r && funct == F_ADD: begin
        aluctr = CTR_W'(ALU_ADD);
        a = rs_data; b = rt_data;
        wr_reg = rd; ctl.reg_write = 1'b1;
      end
      is_r && funct == F_SUB: begin
        aluctr = CTR_W'(ALU_SUB);
        a = rs_data; b = rt_data;
        wr_reg = rd; ctl.reg_write = 1'b1;
      end
      is_r && funct == F_AND: begin
        aluctr = CTR_W'(ALU_AND);
        a = rs_data; b = rt_data;
        wr_reg = rd; ctl.reg_write = 1'b1;
      end
      is_r && funct == F_OR: begin
        aluctr = CTR_W'(ALU_OR);
        a = rs_data; b = rt_data;
        wr_reg = rd; ctl.reg_write = 1'b1;
      end
      is_r && funct == F_XOR: begin
        aluctr = CTR_W'(ALU_XOR);
        a = rs_data; b = rt_data;
        wr_reg = rd; ctl.reg_write = 1'b1;
      end
      is_r && funct == F_SLL: begin
        aluctr = CTR_W'(ALU_SLL);
        a = zsh; b = rt_data;
        wr_reg = rd; ctl.reg_write = 1'b1;
      end
      is_r && funct == F_SRL: begin
        aluctr = CTR_W'(ALU_SRL);
        a = zsh; b = rt_data;
        wr_reg = rd; ctl.reg_write = 1'b1;
      end
      is_r && funct == F_SRA: begin
        aluctr = CTR_W'(ALU_SRA);
        a = zsh; b = rt_data;
        wr_reg = rd; ctl.reg_write = 1'b1;
      end
      is_r && funct == F_JR: begin
        aluctr = CTR_W'(ALU_JR);
        a = rs_data;
        ctl.jump_reg = 1'b1;
      end
      op == OP_ADDI: begin
        aluctr = CTR_W'(ALU_ADD);
        a = rs_data; b = simm;
        wr_reg = rt; ctl.reg_write = 1'b1;
      end
      op == OP_ANDI: begin
        aluctr = CTR_W'(ALU_AND);
        a = rs_data; b = zimm;
        wr_reg = rt; ctl.reg_write = 1'b1;
      end
      op == OP_ORI: begin
        aluctr = CTR_W'(ALU_OR);
        a = rs_data; b = zimm;
        wr_reg = rt; ctl.reg_write = 1'b1;
      end
      op == OP_XORI: begin
        aluctr = CTR_W'(ALU_XOR);
        a = rs_data; b = zimm;
        wr_reg = rt; ctl.reg_write = 1'b1;
      end
      op == OP_LW: begin
        aluctr = CTR_W'(ALU_ADDU);
        a = rs_data; b = simm;
        wr_reg = rt;
        ctl.reg_write = 1'b1;
        ctl.mem_read = 1'b1;
      end
      op == OP_SW: begin
        aluctr = CTR_W'(ALU_ADDU);
        a = rs_data; b = simm;
        ctl.mem_write = 1'b1;
      end
      op == OP_BEQ: begin
        aluctr = CTR_W'(ALU_SUBU);
        a = rs_data; b = rt_data;
        ctl.branch = 1'b1;
      end
      op == OP_LUI: begin
        aluctr = CTR_W'(ALU_LUI);
        b = zimm;
        wr_reg = rt; ctl.reg_write = 1'b1;
      end
      default: ctl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_decode.sv
// Registered decode/issue stage feeding the ALU, with a 2-entry
// (output + skid) buffer behind valid/ready handshakes.
module alu_issue_decode
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CTR_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTR_W-1:0]  ALUctr,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [4:0]        wr_reg,
  output logic              reg_write,
  output logic              mem_read,
  output logic              mem_write,
  output logic              branch,
  output logic              jump_reg,
  output logic              illegal
);

  localparam int PW = CTR_W + 2*DATA_W + 5 + $bits(alu_ctl_t);

  logic [CTR_W-1:0]  d_ctr;
  logic [DATA_W-1:0] d_a;
  logic [DATA_W-1:0] d_b;
  logic [4:0]        d_wr;
  alu_ctl_t          d_ctl;
  alu_ctl_t          o_ctl;
  logic [PW-1:0]     dec;

  logic          out_v, out_v_n;
  logic          skid_v, skid_v_n;
  logic          rdy_q;
  logic [PW-1:0] out_q, out_q_n;
  logic [PW-1:0] skid_q, skid_q_n;
  logic          acc;
  logic          ret;

  alu_decode_comb #(
    .DATA_W (DATA_W),
    .CTR_W  (CTR_W)
  ) u_dec (
    .op      (instr[31:26]),
    .rt      (instr[20:16]),
    .imm     (instr[15:0]),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .aluctr  (d_ctr),
    .a       (d_a),
    .b       (d_b),
    .wr_reg  (d_wr),
    .ctl     (d_ctl)
  );

  assign dec = {d_ctr, d_a, d_b, d_wr, d_ctl};
  assign acc = in_valid && rdy_q;
  assign ret = out_v && out_ready;

  always_comb begin
    out_v_n  = out_v;
    skid_v_n = skid_v;
    out_q_n  = out_q;
    skid_q_n = skid_q;
    if (flush) begin
      out_v_n  = 1'b0;
      skid_v_n = 1'b0;
      out_q_n  = '0;
    end else if (!out_v || ret) begin
      // skid is only ever full while out is full, so acc is 0 here
      if (skid_v) begin
        out_q_n  = skid_q;
        out_v_n  = 1'b1;
        skid_v_n = 1'b0;
      end else begin
        out_v_n = acc;
        if (acc) out_q_n = dec;
      end
    end else if (acc) begin
      skid_q_n = dec;
      skid_v_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b1;
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      out_v  <= out_v_n;
      skid_v <= skid_v_n;
      rdy_q  <= !skid_v_n;
      out_q  <= out_q_n;
      skid_q <= skid_q_n;
    end
  end

  assign in_ready  = rdy_q;
  assign out_valid = out_v;
  assign {ALUctr, A, B, wr_reg, o_ctl} = out_q;
  assign reg_write = o_ctl.reg_write;
  assign mem_read  = o_ctl.mem_read;
  assign mem_write = o_ctl.mem_write;
  assign branch    = o_ctl.branch;
  assign jump_reg  = o_ctl.jump_reg;
  assign illegal   = o_ctl.illegal;

endmodule

// File: tb/tb_alu_issue_decode.sv
// Directed bench for alu_issue_decode: decode table, skid-buffer
// backpressure, flush and asynchronous reset.
module tb_alu_issue_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instr;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  ALUctr;
  logic [31:0] A;
  logic [31:0] B;
  logic [4:0]  wr_reg;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        branch;
  logic        jump_reg;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue_decode #(.DATA_W(32), .CTR_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .instr     (instr),
    .rs_data   (rs_data),
    .rt_data   (rt_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .ALUctr    (ALUctr),
    .A         (A),
    .B         (B),
    .wr_reg    (wr_reg),
    .reg_write (reg_write),
    .mem_read  (mem_read),
    .mem_write (mem_write),
    .branch    (branch),
    .jump_reg  (jump_reg),
    .illegal   (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i,
                       input logic [31:0] rs, input logic [31:0] rt);
    in_valid = v;
    instr    = i;
    rs_data  = rs;
    rt_data  = rt;
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    #3;
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_A", A, 32'd0);
    chk("rst_ALUctr", {28'b0, ALUctr}, 32'd0);
    #9;
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

    // add $3,$1,$2
    out_ready = 1'b1;
    drive(1'b1, 32'h00221820, 32'h34, 32'h12);
    tick();
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_ctr", {28'b0, ALUctr}, 32'hE);
    chk("add_A", A, 32'h34);
    chk("add_B", B, 32'h12);
    chk("add_wr", {27'b0, wr_reg}, 32'd3);
    chk("add_rw", {31'b0, reg_write}, 32'd1);

    // sll $2,$1,3
    drive(1'b1, 32'h000110C0, 32'h55, 32'hFFFFFFFF);
    tick();
    chk("sll_ctr", {28'b0, ALUctr}, 32'hA);
    chk("sll_A", A, 32'd3);
    chk("sll_B", B, 32'hFFFFFFFF);
    chk("sll_wr", {27'b0, wr_reg}, 32'd2);

    // lw $5,-4($1)
    drive(1'b1, 32'h8C25FFFC, 32'h100, 32'h77);
    tick();
    chk("lw_ctr", {28'b0, ALUctr}, 32'h1);
    chk("lw_A", A, 32'h100);
    chk("lw_B", B, 32'hFFFFFFFC);
    chk("lw_mr", {31'b0, mem_read}, 32'd1);
    chk("lw_rw", {31'b0, reg_write}, 32'd1);
    chk("lw_wr", {27'b0, wr_reg}, 32'd5);

    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("idle_valid", {31'b0, out_valid}, 32'd0);

    // backpressure: ori, xori, addi with out stalled
    out_ready = 1'b0;
    drive(1'b1, 32'h342400FF, 32'hF0F0, 32'h0);
    tick();
    chk("bp1_valid", {31'b0, out_valid}, 32'd1);
    chk("bp1_rdy", {31'b0, in_ready}, 32'd1);
    chk("bp1_A", A, 32'hF0F0);
    drive(1'b1, 32'h38268000, 32'h1234, 32'h0);
    tick();
    chk("bp2_rdy", {31'b0, in_ready}, 32'd0);
    chk("bp2_ctr", {28'b0, ALUctr}, 32'h3);
    chk("bp2_B", B, 32'hFF);
    drive(1'b1, 32'h2027FFFF, 32'h5, 32'h0);
    tick();
    chk("bp3_rdy", {31'b0, in_ready}, 32'd0);
    chk("bp3_wr", {27'b0, wr_reg}, 32'd4);
    out_ready = 1'b1;
    tick();
    chk("bp4_valid", {31'b0, out_valid}, 32'd1);
    chk("bp4_ctr", {28'b0, ALUctr}, 32'h7);
    chk("bp4_B", B, 32'h8000);
    chk("bp4_wr", {27'b0, wr_reg}, 32'd6);
    chk("bp4_rdy", {31'b0, in_ready}, 32'd1);
    tick();
    chk("bp5_ctr", {28'b0, ALUctr}, 32'hE);
    chk("bp5_A", A, 32'h5);
    chk("bp5_B", B, 32'hFFFFFFFF);
    chk("bp5_wr", {27'b0, wr_reg}, 32'd7);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("bp6_valid", {31'b0, out_valid}, 32'd0);

    // flush with both entries full: beq then sw
    out_ready = 1'b0;
    drive(1'b1, 32'h10220004, 32'h9, 32'hA);
    tick();
    chk("beq_br", {31'b0, branch}, 32'd1);
    chk("beq_ctr", {28'b0, ALUctr}, 32'h5);
    chk("beq_wr", {27'b0, wr_reg}, 32'd0);
    drive(1'b1, 32'hAC220008, 32'h9, 32'hA);
    tick();
    chk("fl_full", {31'b0, in_ready}, 32'd0);
    flush = 1'b1;
    drive(1'b1, 32'h00221820, 32'h1, 32'h2);
    tick();
    chk("fl_valid", {31'b0, out_valid}, 32'd0);
    chk("fl_rdy", {31'b0, in_ready}, 32'd1);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("fl_after", {31'b0, out_valid}, 32'd0);

    // flush drops an entry whose handshake completes that cycle
    flush = 1'b1;
    drive(1'b1, 32'h8C25FFFC, 32'h100, 32'h0);
    tick();
    chk("fl2_valid", {31'b0, out_valid}, 32'd0);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("fl2_after", {31'b0, out_valid}, 32'd0);

    // illegal, nop, jr, lui streamed at full rate
    drive(1'b1, 32'hFC000000, 32'h7, 32'h9);
    tick();
    chk("ill_valid", {31'b0, out_valid}, 32'd1);
    chk("ill_flag", {31'b0, illegal}, 32'd1);
    chk("ill_ctr", {28'b0, ALUctr}, 32'h0);
    chk("ill_A", A, 32'h0);
    chk("ill_B", B, 32'h0);
    chk("ill_rw", {31'b0, reg_write}, 32'd0);
    chk("ill_mw", {31'b0, mem_write}, 32'd0);
    drive(1'b1, 32'h00000000, 32'h7, 32'h9);
    tick();
    chk("nop_ill", {31'b0, illegal}, 32'd0);
    chk("nop_ctr", {28'b0, ALUctr}, 32'hA);
    chk("nop_wr", {27'b0, wr_reg}, 32'd0);
    chk("nop_B", B, 32'h9);
    drive(1'b1, 32'h03E00008, 32'hDEAD, 32'h9);
    tick();
    chk("jr_ctr", {28'b0, ALUctr}, 32'hC);
    chk("jr_A", A, 32'hDEAD);
    chk("jr_B", B, 32'h0);
    chk("jr_jr", {31'b0, jump_reg}, 32'd1);
    chk("jr_rw", {31'b0, reg_write}, 32'd0);
    drive(1'b1, 32'h3C05ABCD, 32'h1111, 32'h2222);
    tick();
    chk("lui_ctr", {28'b0, ALUctr}, 32'h6);
    chk("lui_A", A, 32'h0);
    chk("lui_B", B, 32'hABCD);
    chk("lui_wr", {27'b0, wr_reg}, 32'd5);

    // async reset with both entries buffered
    out_ready = 1'b0;
    drive(1'b1, 32'h00221820, 32'h1, 32'h2);
    tick();
    tick();
    chk("ar_full", {31'b0, in_ready}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", {31'b0, out_valid}, 32'd0);
    chk("ar_rdy", {31'b0, in_ready}, 32'd1);
    chk("ar_A", A, 32'h0);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    #10;
    rst_n = 1'b1;
    tick();
    chk("ar_after", {31'b0, out_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
